// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and architectural constants.
package fetch_unit_pkg;

  localparam int unsigned ADDRESS_SIZE     = 16;
  localparam int unsigned INSTRUCTION_SIZE = 32;
  localparam int unsigned FETCH_DEPTH      = 2;

  // Opcode occupies the top six bits of every instruction word.
  typedef enum logic [5:0] {
    OP_ALU    = 6'h00,
    OP_LOAD   = 6'h01,
    OP_STORE  = 6'h02,
    OP_BRANCH = 6'h03,
    OP_NOP    = 6'h3F
  } opcode_t;

  localparam logic [INSTRUCTION_SIZE-1:0] NOP_INSTRUCTION =
    {OP_NOP, {(INSTRUCTION_SIZE - 6){1'b0}}};

  typedef struct packed {
    logic [ADDRESS_SIZE-1:0]     address;
    logic [INSTRUCTION_SIZE-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with push, pop, flush and occupancy count.
module fetch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  function automatic logic [PW-1:0] advance(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping; flush overrides any push or pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= advance(wr_ptr);
      if (pop)  rd_ptr <= advance(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Data storage needs no reset; only occupied slots are ever read.
  always_ff @(posedge clock) begin
    if (push && !flush) storage[wr_ptr] <= push_data;
  end

  assign head = storage[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC sequencing, credit-limited memory requests, prefetch
// buffering, squash on jump and the registered pc/instruction output.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        jump,
  input  logic [ADDRESS_SIZE-1:0]     jump_address,
  output logic                        imem_request,
  output logic [ADDRESS_SIZE-1:0]     imem_address,
  input  logic                        imem_valid,
  input  logic [INSTRUCTION_SIZE-1:0] imem_data,
  output logic [ADDRESS_SIZE-1:0]     pc,
  output logic [INSTRUCTION_SIZE-1:0] instruction
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [ADDRESS_SIZE-1:0] fetch_pc;
  logic [ADDRESS_SIZE-1:0] tag_head;
  logic [CW-1:0]           outstanding;
  logic [CW-1:0]           discard;
  logic [CW-1:0]           count;
  logic [CW:0]             credit_used;
  logic                    pop;
  logic                    issue;
  logic                    accept;
  fetch_entry_t            head_entry;
  fetch_entry_t            push_entry;

  assign pop         = !jump && !stall && (count != '0);
  assign credit_used = {1'b0, outstanding} + {1'b0, count} - (CW + 1)'(pop);
  // Gated by reset so no request leaves while the memory is held in reset.
  assign issue       = reset && !jump && (credit_used < (CW + 1)'(DEPTH));
  assign accept      = imem_valid && (discard == '0);
  assign push_entry  = '{address: tag_head, word: imem_data};

  assign imem_request = issue;
  assign imem_address = fetch_pc;

  // Tag queue occupancy doubles as the outstanding-request count: it is never
  // flushed, so squashed requests keep their credit until their response lands.
  fetch_fifo #(
    .WIDTH (ADDRESS_SIZE),
    .DEPTH (DEPTH)
  ) tag_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (issue),
    .push_data (fetch_pc),
    .pop       (imem_valid),
    .flush     (1'b0),
    .head      (tag_head),
    .count     (outstanding)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) prefetch (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (jump),
    .head      (head_entry),
    .count     (count)
  );

  // Next address to request: redirect on jump, advance on each issue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     fetch_pc <= '0;
    else if (jump)  fetch_pc <= jump_address;
    else if (issue) fetch_pc <= fetch_pc + 1'b1;
  end

  // Responses still owed to squashed requests are counted down and dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                          discard <= '0;
    else if (jump)                       discard <= outstanding - CW'(imem_valid);
    else if (imem_valid && discard != '0) discard <= discard - 1'b1;
  end

  // Registered pc/instruction toward the read stage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc          <= '0;
      instruction <= NOP_INSTRUCTION;
    end else if (jump) begin
      instruction <= NOP_INSTRUCTION;
    end else if (!stall) begin
      if (pop) begin
        pc          <= head_entry.address;
        instruction <= head_entry.word;
      end else begin
        instruction <= NOP_INSTRUCTION;
      end
    end
  end

  a_no_spurious_response: assert property (
    @(posedge clock) disable iff (!reset) imem_valid |-> (outstanding != '0)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with an in-order variable-latency memory.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'hFC00_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        jump  = 1'b0;
  logic [15:0] jump_address = '0;
  logic        imem_request;
  logic [15:0] imem_address;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_data  = '0;
  logic [15:0] pc;
  logic [31:0] instruction;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned lat    = 1;
  int unsigned cyc    = 0;

  typedef struct { int unsigned due; logic [15:0] addr; } pend_t;
  typedef struct { logic [15:0] addr; logic [31:0] word; } exp_t;
  pend_t pend[$];
  exp_t  exp_q[$];
  logic [15:0] next_req = '0;
  int          out_cnt  = 0;
  bit          jump_seen = 1'b0;

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .jump         (jump),
    .jump_address (jump_address),
    .imem_request (imem_request),
    .imem_address (imem_address),
    .imem_valid   (imem_valid),
    .imem_data    (imem_data),
    .pc           (pc),
    .instruction  (instruction)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_of(input logic [15:0] a);
    return 32'h1000 + {16'h0, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model plus request-side scoreboard feed.
  initial begin : memory
    pend_t p;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (imem_valid) out_cnt--;
        if (jump) check("no_req_on_jump", {63'h0, imem_request}, 64'h0);
        if (imem_request) begin
          check("req_addr", {48'h0, imem_address}, {48'h0, next_req});
          p.due  = cyc + lat;
          p.addr = imem_address;
          pend.push_back(p);
          exp_q.push_back('{addr: next_req, word: word_of(next_req)});
          next_req = next_req + 16'h1;
          out_cnt++;
        end
        check("credit", {63'h0, out_cnt <= int'(DEPTH)}, 64'h1);
        if (jump) begin
          next_req  = jump_address;
          jump_seen = 1'b1;
        end
      end
      @(posedge clock);
      #1;
      cyc++;
      if (!reset) begin
        pend.delete();
        exp_q.delete();
        next_req   = '0;
        out_cnt    = 0;
        jump_seen  = 1'b0;
        imem_valid = 1'b0;
      end else begin
        if (jump_seen) begin
          exp_q.delete();
          jump_seen = 1'b0;
        end
        if (pend.size() > 0 && pend[0].due == cyc) begin
          p          = pend.pop_front();
          imem_valid = 1'b1;
          imem_data  = word_of(p.addr);
        end else begin
          imem_valid = 1'b0;
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every newly presented instruction.
  initial begin : monitor
    bit          prev_ok = 1'b0, p_jump = 1'b0, p_stall = 1'b0;
    bit          awaiting = 1'b0, window_stall = 1'b0;
    logic [15:0] p_pc = '0;
    logic [31:0] p_instr = '0;
    int unsigned mark = 0, exp_lat = 0;
    exp_t        e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_ok  = 1'b0;
        awaiting = 1'b0;
        continue;
      end
      if (!prev_ok) begin
        awaiting = 1'b1; mark = cyc; exp_lat = lat + 2; window_stall = 1'b0;
      end else if (p_jump) begin
        check("jump_nop", {32'h0, instruction}, {32'h0, NOP});
        check("jump_pc_hold", {48'h0, pc}, {48'h0, p_pc});
      end else if (p_stall) begin
        check("stall_pc_hold", {48'h0, pc}, {48'h0, p_pc});
        check("stall_instr_hold", {32'h0, instruction}, {32'h0, p_instr});
      end else if (instruction != NOP) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {48'h0, pc}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", {48'h0, pc}, {48'h0, e.addr});
          check("out_instr", {32'h0, instruction}, {32'h0, e.word});
        end
        if (awaiting) begin
          if (!window_stall) check("first_latency", 64'(cyc - mark), 64'(exp_lat));
          awaiting = 1'b0;
        end
      end else begin
        check("idle_pc_hold", {48'h0, pc}, {48'h0, p_pc});
      end
      if (jump) begin
        awaiting = 1'b1; mark = cyc; exp_lat = lat + 3; window_stall = 1'b0;
      end else if (stall) begin
        window_stall = 1'b1;
      end
      p_jump = jump; p_stall = stall; p_pc = pc; p_instr = instruction;
      prev_ok = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int unsigned l);
    @(posedge clock);
    #3;
    reset = 1'b0; stall = 1'b0; jump = 1'b0; lat = l;
    repeat (2) @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b1;
  endtask

  task automatic wait_pc(input logic [15:0] target, input int unsigned budget);
    bit found = 1'b0;
    for (int unsigned i = 0; i < budget && !found; i++) begin
      @(negedge clock);
      if (pc == target && instruction != NOP) found = 1'b1;
    end
    check("wait_pc_reached", {63'h0, found}, 64'h1);
  endtask

  task automatic do_jump(input logic [15:0] a, input logic with_stall);
    tick();
    jump = 1'b1; jump_address = a; stall = with_stall;
    tick();
    jump = 1'b0; stall = 1'b0;
  endtask

  initial begin : stimulus
    #2 reset = 1'b0;
    #1;
    check("reset_pc", {48'h0, pc}, 64'h0);
    check("reset_instr", {32'h0, instruction}, {32'h0, NOP});
    check("reset_req", {63'h0, imem_request}, 64'h0);
    check("reset_addr", {48'h0, imem_address}, 64'h0);
    lat = 1;
    repeat (2) @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;

    // Straight-line start-up with single-cycle memory.
    repeat (3) @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("start_pc", {48'h0, pc}, 64'(k));
      check("start_instr", {32'h0, instruction}, {32'h0, word_of(16'(k))});
    end

    // Three-cycle stall while pc 5 is presented.
    wait_pc(16'h4, 20);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stall_pc", {48'h0, pc}, 64'h5);
      check("stall_instr", {32'h0, instruction}, {32'h0, word_of(16'h5)});
    end
    tick();
    stall = 1'b0;
    @(negedge clock);
    check("stall_last_pc", {48'h0, pc}, 64'h5);
    for (int k = 6; k < 9; k++) begin
      @(negedge clock);
      check("after_stall_pc", {48'h0, pc}, 64'(k));
      check("after_stall_instr", {32'h0, instruction}, {32'h0, word_of(16'(k))});
    end

    // Jump with requests in flight, three-cycle memory.
    do_reset(3);
    repeat (12) tick();
    do_jump(16'h0020, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("jump_wait_nop", {32'h0, instruction}, {32'h0, NOP});
    end
    for (int k = 32; k < 35; k++) begin
      @(negedge clock);
      check("jump_seq_pc", {48'h0, pc}, 64'(k));
      check("jump_seq_instr", {32'h0, instruction}, {32'h0, word_of(16'(k))});
    end

    // Jump and stall in the same cycle.
    do_jump(16'h0040, 1'b1);
    @(negedge clock);
    check("jump_stall_nop", {32'h0, instruction}, {32'h0, NOP});
    wait_pc(16'h0040, 20);

    // Address wrap-around.
    do_jump(16'hFFFF, 1'b0);
    wait_pc(16'hFFFF, 20);
    wait_pc(16'h0000, 5);
    repeat (6) tick();

    // Randomized stall/jump traffic at each latency.
    for (int unsigned ph = 0; ph < 3; ph++) begin
      do_reset(1 + ph);
      for (int i = 0; i < 300; i++) begin
        tick();
        stall = ($urandom_range(0, 3) == 0);
        jump  = ($urandom_range(0, 29) == 0);
        if (jump) jump_address = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      end
      tick();
      stall = 1'b0; jump = 1'b0;
      repeat (10) tick();
    end

    // Asynchronous reset in the middle of traffic.
    do_reset(3);
    repeat (12) tick();
    stall = 1'b1;
    repeat (3) tick();
    @(posedge clock);
    #3 reset = 1'b0; stall = 1'b0;
    #1;
    check("midreset_pc", {48'h0, pc}, 64'h0);
    check("midreset_instr", {32'h0, instruction}, {32'h0, NOP});
    check("midreset_req", {63'h0, imem_request}, 64'h0);
    check("midreset_addr", {48'h0, imem_address}, 64'h0);
    repeat (2) @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    wait_pc(16'h0000, 10);
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #300000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

First pipeline stage of the core. It keeps the fetch program counter and issues in-order requests to the instruction memory. It buffers returned instruction words in a small prefetch FIFO and presents one `pc`/`instruction` pair per cycle to the read stage. It obeys the read stage's `stall`, and on `jump` it redirects to `jump_address`, squashing everything in flight.

## Interface

Parameters:
- `DEPTH`, 2: prefetch FIFO entries; also the maximum number of outstanding memory requests (credit limit); ≥2.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `stall`  in  1  downstream not accepting; hold outputs.
- `jump`  in  1  redirect request from the execute stage.
- `jump_address`  in  `ADDRESS_SIZE`  redirect target, valid with `jump`.
- `imem_request`  out  1  request strobe, one word per asserted cycle.
- `imem_address`  out  `ADDRESS_SIZE`  word address of the request.
- `imem_valid`  in  1  response strobe. Responses are in order, latency ≥1 cycle, no backpressure.
- `imem_data`  in  `INSTRUCTION_SIZE`  returned instruction word.
- `pc`  out  `ADDRESS_SIZE`  address of the presented instruction; registered.
- `instruction`  out  `INSTRUCTION_SIZE`  presented instruction; registered; `NOP_INSTRUCTION` when no instruction is available.

## Operation

- **Internal state:**
  - `fetch_pc`: next address to request.
  - `outstanding`: 0..DEPTH, all in-flight requests, squashed ones included.
  - `discard`: 0..outstanding, responses still to be dropped.
  - FIFO of {address, word}, with `count`.
- **pop** = `!jump && !stall && count>0`.
- **Issue:**
  - Condition: `!jump && (outstanding + count - pop) < DEPTH`.
  - Action: drive `imem_request`=1 and `imem_address`=`fetch_pc`, then `fetch_pc` += 1, wrapping modulo 2^ADDRESS_SIZE.
  - The request address is pushed into an address-tag queue that pairs it with its response.
- **Response** (`imem_valid`):
  - `outstanding` -= 1.
  - If `discard>0`, the response is dropped and `discard` -= 1.
  - Otherwise {tag, `imem_data`} is pushed into the FIFO.
  - A push and a pop in the same cycle are legal.
- **Output register:**
  - jump: `instruction` ← `NOP_INSTRUCTION`; `pc` holds.
  - Else if stall: both hold.
  - Else if pop: both ← FIFO head.
  - Else: `instruction` ← `NOP_INSTRUCTION`; `pc` holds.
- **Jump** (priority over stall):
  - `fetch_pc` ← `jump_address`.
  - FIFO flushed, including any push in the same cycle.
  - `discard` ← `outstanding` minus any response consumed in the jump cycle.
  - No request is issued in the jump cycle.
- Memory errors do not exist. `imem_valid` with `outstanding`=0 is illegal and is asserted against in simulation.

## Timing

- **Reset values:** `pc`=0, `instruction`=`NOP_INSTRUCTION`, `imem_request`=0, `imem_address`=0, `fetch_pc`=0, counters and FIFO empty.
- **Start-up:** the first request (address 0) is issued in the first cycle after `reset` deasserts.
- **Latency:** for memory latency L, a word requested in cycle t appears on `instruction` after the edge ending cycle t+L+1. There is no combinational path from `imem_data` to the outputs.
- **Throughput:** one instruction per cycle when L=1 and DEPTH=2. Generally, throughput requires DEPTH ≥ L+1.
- **After a jump in cycle t:**
  - A request to `jump_address` is issued in t+1.
  - The first valid output appears at t+L+2.
  - NOP is presented in the meantime.
- **Reset mid-operation:** all state clears immediately. The instruction memory is reset by the same `reset`, so no stale response follows.

## Structure

- Add `NOP_INSTRUCTION` to `architecture.vh`: `NOP` in the opcode field, all other bits zero. Also add `FETCH_DEPTH` (default 2) there.
- Sub-module `fetch_fifo`: synchronous FIFO of {address, instruction} with push, pop, flush and count. It is also reused for the address-tag queue, with width `ADDRESS_SIZE`.
- Credit, discard and output logic stay in `fetch_unit`.

## Test plan

- **Straight-line start-up:** memory with L=1 holding word k = 0x1000+k; release reset. Required response:
  - `imem_address` 0,1,2… on consecutive cycles;
  - `pc`/`instruction` = 0/0x1000, 1/0x1001, … every cycle from the third cycle after release.
- **Stall:** stall for 3 cycles mid-stream while presenting pc 5. Required response:
  - outputs hold pc 5 for the whole stall;
  - `outstanding + count` never exceeds 2;
  - after release, pc 6, 7… follow with no gap and no loss.
- **Jump with in-flight requests:** L=3, DEPTH=4, jump to 0x20 while 3 requests are outstanding. Required response:
  - the 3 stale responses are dropped;
  - `NOP_INSTRUCTION` is presented until `pc`=0x20 appears, 5 cycles after the jump cycle;
  - then 0x21, 0x22… follow.
- **Jump and stall together:** `jump`=`stall`=1 in the same cycle. Required response:
  - the jump is taken;
  - `instruction` = NOP on the next edge.
- **Wrap-around:** jump to 2^ADDRESS_SIZE−1. Required response: requests go to max, then 0; outputs follow the same order.
- **Reset mid-operation:** assert `reset` with 2 outstanding requests and 1 FIFO entry. Required response:
  - all outputs take their reset values asynchronously;
  - after release, fetch restarts at 0.
